// File: rtl/btn_req_latch.sv
// ============================================================================
//  Module   : btn_req_latch
//  Purpose  : Synchronise and debounce raw buttons into sticky request bits
//  Revision : 1.0
// ============================================================================
`default_nettype none

module btn_req_latch #(
   parameter int N_CH         = 4,
   parameter int DEBOUNCE_CYC = 16,
   parameter int CNT_W        = $clog2(DEBOUNCE_CYC) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] btn_in,
   input  logic            clr,
   output logic [N_CH-1:0] req,
   output logic            req_valid,
   output logic            new_press
);

   localparam logic [CNT_W-1:0] c_CNT_TERM = CNT_W'(DEBOUNCE_CYC - 1);

   logic [N_CH-1:0] s1_q;
   logic [N_CH-1:0] s2_q;
   logic [N_CH-1:0] rise_w;
   logic [N_CH-1:0] req_q;
   logic [N_CH-1:0] req_d;
   logic [N_CH-1:0] req_kept_w;
   logic            new_press_q;
   logic            new_press_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= btn_in;
         s2_q <= s1_q;
      end
   end

   // Each channel needs DEBOUNCE_CYC consecutive disagreeing synced samples
   // before the accepted level moves; any agreement restarts the count.
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic             stable_q;
      logic             stable_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             term_w;

      assign term_w    = (s2_q[i] != stable_q) && (cnt_q == c_CNT_TERM);
      assign rise_w[i] = term_w & s2_q[i];

      always_comb begin
         stable_d = stable_q;
         cnt_d    = '0;
         if (term_w) begin
            stable_d = s2_q[i];
         end else if (s2_q[i] != stable_q) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
         end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
         end
      end
   end

   // A rise on the clearing edge survives the clear for its own bit.
   always_comb begin
      req_kept_w  = clr ? '0 : req_q;
      req_d       = req_kept_w | rise_w;
      new_press_d = |(rise_w & ~req_kept_w);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q       <= '0;
         new_press_q <= 1'b0;
      end else begin
         req_q       <= req_d;
         new_press_q <= new_press_d;
      end
   end

   assign req       = req_q;
   assign req_valid = |req_q;
   assign new_press = new_press_q;

endmodule

`default_nettype wire

// File: tb/tb_btn_req_latch.sv
// ============================================================================
//  Module   : tb_btn_req_latch
//  Purpose  : Scoreboard bench for btn_req_latch against a run-length model
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_btn_req_latch;

   localparam int N  = 4;
   localparam int DB = 16;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b1;
   logic         clr   = 1'b0;
   logic [N-1:0] btn_in = '0;
   logic [N-1:0] req;
   logic         req_valid;
   logic         new_press;

   btn_req_latch #(.N_CH(N), .DEBOUNCE_CYC(DB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_in    (btn_in),
      .clr       (clr),
      .req       (req),
      .req_valid (req_valid),
      .new_press (new_press)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [N-1:0] req;
      logic         np;
      logic         rv;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   // Reference: inputs reach the debouncer two edges late; a level is
   // accepted once it has disagreed with the accepted level for DB edges.
   logic [N-1:0] m_d1, m_d2, m_acc, m_req;
   int           m_run[N];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_d1 = '0; m_d2 = '0; m_acc = '0; m_req = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
   endtask

   task automatic model_edge(input logic [N-1:0] b, input logic c);
      logic [N-1:0] sync, rise, kept;
      exp_t         e;
      logic         np;
      sync = m_d2;
      m_d2 = m_d1;
      m_d1 = b;
      rise = '0;
      for (int i = 0; i < N; i++) begin
         if (sync[i] != m_acc[i]) begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == DB) begin
               m_acc[i] = sync[i];
               m_run[i] = 0;
               rise[i]  = sync[i];
            end
         end else begin
            m_run[i] = 0;
         end
      end
      kept  = c ? '0 : m_req;
      np    = (rise & ~kept) != '0;
      m_req = kept | rise;
      e.req = m_req;
      e.np  = np;
      e.rv  = (m_req != '0);
      sbq.push_back(e);
   endtask

   task automatic step(input logic [N-1:0] b, input logic c);
      @(negedge clk);
      btn_in = b;
      clr    = c;
      rst_n  = 1'b1;
      @(posedge clk);
      model_edge(b, c);
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_req", 32'(req), 32'h0);
      chk("rst_np", 32'(new_press), 32'h0);
      chk("rst_rv", 32'(req_valid), 32'h0);
      model_reset();
      repeat (cycles) @(posedge clk);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("req", 32'(req), 32'(e.req));
            chk("new_press", 32'(new_press), 32'(e.np));
            chk("req_valid", 32'(req_valid), 32'(e.rv));
         end
      end
   end

   initial begin : stim
      logic [N-1:0] lvl;
      int           hold[N];
      int           guard;

      model_reset();
      #3;
      do_reset(3);

      // clean press, then release holds request
      repeat (30) step(4'b0100, 1'b0);
      repeat (20) step(4'b0000, 1'b0);
      // glitch shorter than the window
      repeat (10) step(4'b0001, 1'b0);
      repeat (20) step(4'b0000, 1'b0);
      // bounce then settle high
      for (int k = 0; k < 12; k++) step(((k / 3) % 2 == 0) ? 4'b1000 : 4'b0000, 1'b0);
      repeat (25) step(4'b1000, 1'b0);
      // clear, then press ch1 and clear it
      step(4'b0000, 1'b1);
      repeat (20) step(4'b0000, 1'b0);
      repeat (25) step(4'b0010, 1'b0);
      step(4'b0010, 1'b1);
      repeat (20) step(4'b0000, 1'b0);
      // clr coincides with ch3 rise on the 18th edge
      repeat (17) step(4'b1000, 1'b0);
      step(4'b1000, 1'b1);
      repeat (5) step(4'b1000, 1'b0);
      repeat (20) step(4'b0000, 1'b0);
      // simultaneous press, then re-press of an already-set bit
      step(4'b0000, 1'b1);
      repeat (25) step(4'b1001, 1'b0);
      repeat (20) step(4'b0000, 1'b0);
      repeat (25) step(4'b0001, 1'b0);
      repeat (20) step(4'b0000, 1'b0);
      // reset mid-debounce with button held through release
      step(4'b0000, 1'b1);
      repeat (10) step(4'b0100, 1'b0);
      do_reset(2);
      repeat (25) step(4'b0100, 1'b0);

      // randomized levels with random hold lengths and sporadic clears
      lvl = '0;
      for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 40);
      for (int t = 0; t < 600; t++) begin
         for (int i = 0; i < N; i++) begin
            hold[i]--;
            if (hold[i] <= 0) begin
               lvl[i]  = ~lvl[i];
               hold[i] = $urandom_range(1, 40);
            end
         end
         step(lvl, ($urandom_range(0, 29) == 0));
      end
      repeat (30) step(4'b0000, 1'b0);

      guard = 0;
      while (sbq.size() > 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      #2;
      if (sbq.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain actual=%0d required=0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
